mul_sequencer: RTL and testbench

Multi-cycle unsigned 32x32->64 multiplier controller that borrows the core's shared 32-bit ALU in its ADD mode for shift-and-add iterations. It sits beside the execute stage. While `alu_busy` is high, the core's ALU input mux selects this block's `alu_control`/`alu_srcA`/`alu_srcB`, and the block consumes `alu_result`. Requests and responses use valid/ready handshakes.

---
 rtl/mul_sequencer.sv | 101 ++++++++++
 tb/tb_mul_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// Multi-cycle unsigned 32x32->64 multiplier controller that borrows the core's shared ALU
// in ADD mode for one shift-and-add iteration per cycle while alu_busy is high.
module mul_sequencer #(
  parameter bit ZERO_FAST = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_hi,
  output logic [31:0] resp_lo,
  output logic        alu_busy,
  output logic [2:0]  alu_control,
  output logic [31:0] alu_srcA,
  output logic [31:0] alu_srcB,
  input  logic [31:0] alu_result
);

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOP = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] mcand;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [4:0]  cnt;

  logic        accept;
  logic        zero_hit;
  logic        last_iter;
  logic [31:0] addend;
  logic        carry;

  assign accept    = (state == IDLE) && req_valid;
  assign zero_hit  = ZERO_FAST && ((req_a == 32'd0) || (req_b == 32'd0));
  assign last_iter = (cnt == 5'd31);
  assign addend    = lo[0] ? mcand : 32'd0;

  // The shared ALU exports no carry, so rebuild it from the operand and sum sign bits.
  assign carry = (hi[31] & addend[31]) | ((hi[31] | addend[31]) & ~alu_result[31]);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: next-state is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = zero_hit ? DONE : BUSY;
      BUSY:    if (last_iter) state_nxt = DONE;
      DONE:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mcand <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      cnt   <= 5'd0;
    end else if (accept) begin
      mcand <= req_a;
      hi    <= 32'd0;
      lo    <= zero_hit ? 32'd0 : req_b;
      cnt   <= 5'd0;
    end else if (state == BUSY) begin
      // {carry, sum, lo} shifted right by one: the 65-bit partial product keeps its low 64 bits.
      hi  <= {carry, alu_result[31:1]};
      lo  <= {alu_result[0], lo[31:1]};
      cnt <= cnt + 5'd1;
    end
  end

  assign req_ready   = (state == IDLE);
  assign resp_valid  = (state == DONE);
  assign resp_hi     = hi;
  assign resp_lo     = lo;
  assign alu_busy    = (state == BUSY);
  assign alu_control = alu_busy ? ALU_ADD : ALU_NOP;
  assign alu_srcA    = alu_busy ? hi : 32'd0;
  assign alu_srcB    = alu_busy ? addend : 32'd0;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: a transaction-level model (product by plain
// multiplication, latency by cycle countdown) is compared every cycle, plus literal spot checks.
module tb_mul_sequencer;

  localparam bit ZF = 1'b1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_hi;
  logic [31:0] resp_lo;
  logic        alu_busy;
  logic [2:0]  alu_control;
  logic [31:0] alu_srcA;
  logic [31:0] alu_srcB;
  logic [31:0] alu_result;

  logic        req_valid2 = 1'b0;
  logic        req_ready2;
  logic [31:0] req_a2 = '0;
  logic [31:0] req_b2 = '0;
  logic        resp_valid2;
  logic        resp_ready2 = 1'b0;
  logic [31:0] resp_hi2;
  logic [31:0] resp_lo2;
  logic        alu_busy2;
  logic [2:0]  alu_control2;
  logic [31:0] alu_srcA2;
  logic [31:0] alu_srcB2;
  logic [31:0] alu_result2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_sequencer #(.ZERO_FAST(ZF)) u_dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hi(resp_hi), .resp_lo(resp_lo),
    .alu_busy(alu_busy), .alu_control(alu_control), .alu_srcA(alu_srcA), .alu_srcB(alu_srcB),
    .alu_result(alu_result)
  );

  mul_sequencer #(.ZERO_FAST(1'b0)) u_dut_slow (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_a(req_a2), .req_b(req_b2),
    .resp_valid(resp_valid2), .resp_ready(resp_ready2), .resp_hi(resp_hi2), .resp_lo(resp_lo2),
    .alu_busy(alu_busy2), .alu_control(alu_control2), .alu_srcA(alu_srcA2), .alu_srcB(alu_srcB2),
    .alu_result(alu_result2)
  );

  // The core's ALU in ADD mode, modulo 2^32.
  assign alu_result  = alu_srcA + alu_srcB;
  assign alu_result2 = alu_srcA2 + alu_srcB2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: 0=idle, 1=multiplying, 2=holding the product.
  int          m_state = 0;
  int          m_left = 0;
  logic [31:0] m_a = '0;
  logic [63:0] m_prod = '0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_state <= 0;
      m_left  <= 0;
    end else begin
      case (m_state)
        0: if (req_valid) begin
          m_a    <= req_a;
          m_prod <= 64'(req_a) * 64'(req_b);
          if (ZF && (req_a == 32'd0 || req_b == 32'd0)) m_state <= 2;
          else begin
            m_state <= 1;
            m_left  <= 32;
          end
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) m_state <= 2;
        end
        default: if (resp_ready) m_state <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      check("req_ready", req_ready, m_state == 0);
      check("alu_busy", alu_busy, m_state == 1);
      check("resp_valid", resp_valid, m_state == 2);
      if (m_state == 2) check("product", {resp_hi, resp_lo}, m_prod);
      if (m_state == 1) begin
        check("alu_control_busy", alu_control, 3'b010);
        check("alu_srcB_choice", (alu_srcB == 32'd0) || (alu_srcB == m_a), 1'b1);
      end else begin
        check("alu_idle_outputs", {alu_control, alu_srcA, alu_srcB}, '0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_accept();
    int n = 0;
    while (!req_ready && n < 300) begin
      step();
      n++;
    end
    check("accept_timeout", req_ready, 1'b1);
    step();
  endtask

  // Called just after the acceptance edge; latency 1 means valid right after that edge.
  task automatic wait_resp(output int lat, output int busy_cnt);
    lat = 1;
    busy_cnt = 0;
    while (!resp_valid && lat < 100) begin
      if (alu_busy) busy_cnt++;
      step();
      lat++;
    end
  endtask

  task automatic take_resp(input int hold, output logic [63:0] p);
    p = {resp_hi, resp_lo};
    resp_ready = 1'b0;
    repeat (hold) step();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int hold,
                         output int lat, output int busy_cnt, output logic [63:0] p);
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    wait_accept();
    req_valid = 1'b0;
    wait_resp(lat, busy_cnt);
    take_resp(hold, p);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    int bc;
    logic [63:0] p;
    logic [63:0] p0;
    logic [31:0] a;
    logic [31:0] b;
    bit zero;

    #12;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_alu_busy", alu_busy, 1'b0);
    check("rst_resp_data", {resp_hi, resp_lo}, 64'd0);
    check("rst_alu_control", alu_control, 3'b000);
    #10;
    rstn = 1'b1;
    step();

    run_mul(32'd3, 32'd5, 0, lat, bc, p);
    check("3x5_latency", lat, 33);
    check("3x5_busy_cycles", bc, 32);
    check("3x5_product", p, 64'h0000_0000_0000_000F);

    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, lat, bc, p);
    check("ffxff_product", p, 64'hFFFF_FFFE_0000_0001);

    run_mul(32'h8000_0000, 32'h0000_0002, 0, lat, bc, p);
    check("msb_x2_product", p, 64'h0000_0001_0000_0000);

    run_mul(32'd0, 32'h1234_5678, 0, lat, bc, p);
    check("zero_fast_latency", lat, 1);
    check("zero_fast_busy", bc, 0);
    check("zero_fast_product", p, 64'd0);

    // Same zero-operand request on the instance without the fast path.
    req_a2 = 32'd0;
    req_b2 = 32'h1234_5678;
    req_valid2 = 1'b1;
    step();
    req_valid2 = 1'b0;
    lat = 1;
    bc = 0;
    while (!resp_valid2 && lat < 100) begin
      if (alu_busy2) bc++;
      step();
      lat++;
    end
    check("slow_zero_latency", lat, 33);
    check("slow_zero_busy", bc, 32);
    check("slow_zero_product", {resp_hi2, resp_lo2}, 64'd0);
    resp_ready2 = 1'b1;
    step();
    resp_ready2 = 1'b0;
    check("slow_back_to_idle", req_ready2, 1'b1);

    // Back-pressure with req_valid held the whole time.
    req_a = 32'h0000_1234;
    req_b = 32'h0000_0100;
    req_valid = 1'b1;
    wait_accept();
    req_a = 32'hDEAD_BEEF;
    req_b = 32'h0000_0003;
    wait_resp(lat, bc);
    check("bp_latency", lat, 33);
    p0 = {resp_hi, resp_lo};
    check("bp_first_product", p0, 64'h0000_0000_0012_3400);
    repeat (10) begin
      step();
      check("bp_stable", {resp_hi, resp_lo}, p0);
      check("bp_req_ready_low", req_ready, 1'b0);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("bp_idle_after_handshake", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    check("bp_second_accepted", alu_busy, 1'b1);
    wait_resp(lat, bc);
    take_resp(0, p);
    check("bp_second_product", p, 64'h0000_0002_9C09_3CCD);

    // Reset pulse in the middle of an iteration run.
    req_a = 32'h1234_5678;
    req_b = 32'h9ABC_DEF0;
    req_valid = 1'b1;
    wait_accept();
    req_valid = 1'b0;
    repeat (15) step();
    check("pre_reset_busy", alu_busy, 1'b1);
    #1;
    rstn = 1'b0;
    #1;
    check("reset_busy_drop", alu_busy, 1'b0);
    check("reset_resp_valid", resp_valid, 1'b0);
    check("reset_alu_control", alu_control, 3'b000);
    #4;
    rstn = 1'b1;
    step();
    check("post_reset_ready", req_ready, 1'b1);
    run_mul(32'd7, 32'd9, 0, lat, bc, p);
    check("7x9_product", p, 64'h0000_0000_0000_003F);

    for (int i = 0; i < 30; i++) begin
      a = pick();
      b = pick();
      zero = (a == 32'd0) || (b == 32'd0);
      repeat ($urandom_range(0, 2)) step();
      resp_ready = ($urandom_range(0, 3) == 0);
      run_mul(a, b, $urandom_range(0, 3), lat, bc, p);
      check("rnd_latency", lat, zero ? 1 : 33);
      check("rnd_busy_cycles", bc, zero ? 0 : 32);
      check("rnd_product", p, 64'(a) * 64'(b));
    end

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
